// File: rtl/croc_sched_if.sv
// Control and status bundle between the croc scheduler and the game logic around it.
// The master side drives the game events; the slave side (the scheduler) drives lane enables and status.
interface croc_sched_if;
  logic        frame_tick;
  logic        start;
  logic        pause;
  logic        hit;
  logic        level_up;
  logic [3:0]  lane_step;
  logic [15:0] lane_speed;
  logic [2:0]  level;
  logic [2:0]  lives;
  logic [2:0]  state;
  logic        game_over;

  modport master (
    output frame_tick, start, pause, hit, level_up,
    input  lane_step, lane_speed, level, lives, state, game_over
  );

  modport slave (
    input  frame_tick, start, pause, hit, level_up,
    output lane_step, lane_speed, level, lives, state, game_over
  );
endinterface

// File: rtl/croc_sched.sv
// Game-state sequencer for the croc lanes: lives/level/freeze control, per-lane frame dividers,
// and a round-robin arbiter that issues at most one lane step pulse per cycle.
module croc_sched #(
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned FREEZE_TICKS = 8
) (
  input logic         clk,
  input logic         rst,
  croc_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    PAUSED = 3'd2,
    FREEZE = 3'd3,
    OVER   = 3'd4
  } state_e;

  state_e      state_q;
  logic [2:0]  lives_q;
  logic [2:0]  level_q;
  logic [7:0]  frz_q;
  logic [1:0]  div_q [4];
  logic [3:0]  pend_q;
  logic [1:0]  rr_q;
  logic [3:0]  step_q;

  logic        tick_run;
  logic        stay_run;
  logic [3:0]  set_d;
  logic [3:0]  grant_d;
  logic [1:0]  grant_idx_d;
  logic [1:0]  idx_d;
  logic [15:0] speed_d;

  assign tick_run = (state_q == RUN) && bus.frame_tick;
  // Grants only when the block stays in RUN, so no step pulse can leak into another state.
  assign stay_run = (state_q == RUN) && !bus.hit && !bus.pause;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign set_d[gi]           = tick_run && (div_q[gi] == 2'd0);
    assign speed_d[4*gi +: 4]  = 4'(gi + 1) + {1'b0, level_q};
  end

  always_comb begin
    grant_d     = '0;
    grant_idx_d = rr_q;
    idx_d       = '0;
    for (int k = 1; k <= 4; k++) begin
      idx_d = rr_q + 2'(k);
      if (grant_d == 4'd0 && pend_q[idx_d]) begin
        grant_d[idx_d] = 1'b1;
        grant_idx_d    = idx_d;
      end
    end
    if (!stay_run) begin
      grant_d     = '0;
      grant_idx_d = rr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lives_q <= LIVES_INIT[2:0];
      level_q <= '0;
      frz_q   <= '0;
      pend_q  <= '0;
      rr_q    <= 2'd3;
      step_q  <= '0;
      for (int i = 0; i < 4; i++) div_q[i] <= '0;
    end else begin
      step_q <= grant_d;
      if (stay_run) begin
        // A lane granted and re-requested in the same cycle keeps its pend bit.
        pend_q <= (pend_q & ~grant_d) | set_d;
        if (grant_d != 4'd0) rr_q <= grant_idx_d;
      end
      if (tick_run) begin
        for (int i = 0; i < 4; i++)
          div_q[i] <= (div_q[i] == 2'd0) ? 2'(i) : div_q[i] - 2'd1;
      end
      case (state_q)
        IDLE, OVER: begin
          if (bus.start) begin
            state_q <= RUN;
            lives_q <= LIVES_INIT[2:0];
            level_q <= '0;
            pend_q  <= '0;
            for (int i = 0; i < 4; i++) div_q[i] <= '0;
          end
        end
        RUN: begin
          if (bus.hit) begin
            pend_q <= '0;
            if (lives_q > 3'd1) begin
              lives_q <= lives_q - 3'd1;
              frz_q   <= FREEZE_TICKS[7:0];
              state_q <= FREEZE;
            end else begin
              lives_q <= '0;
              state_q <= OVER;
            end
          end else if (bus.pause) begin
            pend_q  <= pend_q | set_d;
            state_q <= PAUSED;
          end else if (bus.level_up && level_q != 3'd7) begin
            level_q <= level_q + 3'd1;
          end
        end
        PAUSED: begin
          if (bus.start) state_q <= RUN;
        end
        FREEZE: begin
          if (bus.frame_tick) begin
            frz_q <= frz_q - 8'd1;
            if (frz_q == 8'd1) state_q <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.lane_step  = step_q;
  assign bus.lane_speed = speed_d;
  assign bus.level      = level_q;
  assign bus.lives      = lives_q;
  assign bus.state      = state_q;
  assign bus.game_over  = (state_q == OVER);

endmodule
